// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state type and sizing helper for ex_muldiv.
//   OP_*       : 3-bit op field values presented on ex_muldiv.op
//   state_e    : iterative unit FSM states
//   cnt_width  : bits needed to hold a step counter that counts down from w
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negate, used both to take operand
// magnitudes and to restore result signs.
//   val_i : value to pass through or negate
//   neg_i : 1 = output -val_i, 0 = output val_i
//   res_o : result
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] res_o
);

   assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers beside the EX ALU.
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   start, op      : issue request and op code (sampled only in IDLE)
//   data_a, data_b : rs / rt operands; data_a also sources MTHI/MTLO
//   flush          : cancels any in-flight operation and any same-cycle request
//   busy, stall    : unit occupied / pipeline freeze request (combinational)
//   done           : one-cycle pulse when HI/LO take a mul/div result
//   hi, lo         : HI/LO registers
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_width(WIDTH);
   localparam int W2 = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
   logic             sa_q, sa_d, sb_q, sb_d, div_q, div_d, done_q, done_d;

   logic             is_mul, is_div, is_md, sgn_op, idle_req;
   logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix;
   logic [W2-1:0]    prod_fix, mul_next, div_next;
   logic [WIDTH:0]   mul_sum, r_sh, diff;

   assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
   assign is_md    = is_mul || is_div;
   assign sgn_op   = SIGNED_EN && ((op == OP_MULT) || (op == OP_DIV));
   assign idle_req = (state_q == IDLE) && start && !flush;

   muldiv_signfix #(.WIDTH(WIDTH)) u_mag_a (
      .val_i (data_a),
      .neg_i (sgn_op && data_a[WIDTH-1]),
      .res_o (mag_a)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_mag_b (
      .val_i (data_b),
      .neg_i (sgn_op && data_b[WIDTH-1]),
      .res_o (mag_b)
   );

   // Multiply: acc = {partial product, remaining multiplier bits}; add the
   // multiplicand when the current multiplier LSB is set, then shift right.
   assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend bits / quotient bits}. The shifted
   // remainder needs one extra bit so the trial subtraction's sign is exact.
   assign r_sh     = acc_q[W2-1:WIDTH-1];
   assign diff     = r_sh - {1'b0, opnd_q};
   assign div_next = diff[WIDTH] ? {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   muldiv_signfix #(.WIDTH(W2)) u_fix_prod (
      .val_i (acc_q),
      .neg_i (sa_q ^ sb_q),
      .res_o (prod_fix)
   );

   // A zero divisor leaves the all-ones quotient unsigned-looking regardless of
   // the dividend sign; the remainder then equals the original dividend.
   muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
      .val_i (acc_q[WIDTH-1:0]),
      .neg_i ((sa_q ^ sb_q) && (opnd_q != '0)),
      .res_o (quo_fix)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
      .val_i (acc_q[W2-1:WIDTH]),
      .neg_i (sa_q),
      .res_o (rem_fix)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = (start && is_md) ? (is_div ? DIV : MUL) : IDLE;
         MUL, DIV: state_d = (cnt_q == CW'(1)) ? FIX : state_q;
         FIX:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_comb begin
      busy  = (state_q != IDLE);
      stall = busy || (start && is_md);
   end

   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      opnd_d = opnd_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      div_d  = div_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      if (idle_req && is_md) begin
         cnt_d  = CW'(WIDTH);
         acc_d  = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
         opnd_d = is_div ? mag_b : mag_a;
         sa_d   = sgn_op && data_a[WIDTH-1];
         sb_d   = sgn_op && data_b[WIDTH-1];
         div_d  = is_div;
      end
      if (idle_req && (op == OP_MTHI)) hi_d = data_a;
      if (idle_req && (op == OP_MTLO)) lo_d = data_a;
      if (!flush && ((state_q == MUL) || (state_q == DIV))) begin
         acc_d = (state_q == MUL) ? mul_next : div_next;
         cnt_d = cnt_q - CW'(1);
      end
      if (!flush && (state_q == FIX)) begin
         hi_d   = div_q ? rem_fix : prod_fix[W2-1:WIDTH];
         lo_d   = div_q ? quo_fix : prod_fix[WIDTH-1:0];
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         opnd_q <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         div_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         div_q  <= div_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide unit with HI/LO registers, sitting beside the EX-stage ALU of the MIPS pipeline. It executes MULT, MULTU, DIV, DIVU over multiple cycles and performs MTHI/MTLO in a single cycle. HI/LO are exported continuously so EX can serve MFHI/MFLO. While an operation is in flight it raises a stall that freezes IF/ID/EX, and it accepts a flush that cancels the operation when a branch or jump squashes the issuing instruction.

Parameters:
WIDTH, 32, operand/HI/LO width; must be even and >= 4
SIGNED_EN, 1, 1 = MULT/DIV are signed; 0 = MULT/DIV behave as MULTU/DIVU

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  issue request; sampled only in IDLE
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
data_a  in  WIDTH  rs operand / multiplicand / dividend / MTHI-MTLO source
data_b  in  WIDTH  rt operand / multiplier / divisor
flush  in  1  cancel in-flight operation
busy  out  1  state != IDLE
stall  out  1  busy | (start & op is mul/div); combinational, to pipeline stall logic
done  out  1  one-cycle pulse when HI/LO receive a mul/div result
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0; internal datapath regs cleared.
- States: IDLE -> MUL or DIV -> FIX -> IDLE.
- IDLE, start=1, op MUL*/DIV*: latch |a|, |b| (magnitudes when signed op and SIGNED_EN=1, else raw), latch both sign bits, load counter=WIDTH, go to MUL/DIV.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator; counter decrements; at 0 go to FIX.
- DIV: restoring shift-subtract, one quotient bit per cycle; same counter rule.
- FIX (one cycle): signed product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign. Write hi/lo (product: hi=upper, lo=lower; divide: hi=remainder, lo=quotient); done=1 next cycle; return to IDLE.
- Latency: start sampled at edge E; done high and new hi/lo visible in cycle E+WIDTH+2 (34 for WIDTH=32). busy high from E+1 up to, but not including, the done cycle.
- Divide by zero (data_b=0): still full latency; hi=data_a (original), lo=all ones; no exception.
- Signed MIN / -1: lo=MIN, hi=0 (natural wrap of magnitude algorithm).
- MTHI/MTLO in IDLE: hi (resp. lo) <= data_a at the next edge; no busy, no done, stall stays 0.
- start while busy: ignored; the pipeline is already stalled.
- flush while busy: state->IDLE at next edge; hi/lo unchanged; no done.
- flush with start in IDLE: flush wins; the request is not accepted.
- flush in FIX cycle: the result is discarded and hi/lo are unchanged.
- Reset mid-operation: immediate return to reset values.
- Undefined op codes with start: no effect.

Decomposition:
- Package muldiv_pkg: op encoding constants (OP_MULT ... OP_MTLO), state enum (IDLE/MUL/DIV/FIX), helper to derive counter width as clog2(WIDTH+1).
- One sub-module: muldiv_signfix, parametrised on WIDTH. It is combinational and provides magnitude-of-operand and conditional 2's-complement negate. It is used at operand latch and in the FIX state.

Test Plan:
- MULT a=32'hFFFFFFFD (-3), b=7 -> after 34 cycles done=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; stall high cycles 0..33.
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). Then DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0. DIVU a=5, b=0 -> hi=5, lo=32'hFFFFFFFF.
- Flush: MULT 3*4 issued with hi=0x11, lo=0x22, flush on cycle 10 -> busy=0 on cycle 11, no done, hi=0x11, lo=0x22. A new start on cycle 12 is accepted normally.
- MTHI a=0xABCD then MTLO a=0x1234 on back-to-back cycles -> hi=0xABCD, lo=0x1234, stall never asserted. start with op=DIV while busy -> ignored and the in-flight result is unaffected. rst_n low mid-DIV -> hi=lo=0, busy=0 immediately.
